// File: rtl/ppm_link_phy.sv
// Pulse-position-modulation PHY: TX encoder (preamble + data symbols + closing pulse),
// RX decoder (HUNT/SYNC/DATA interval classifier) and a 32-bit Fibonacci LFSR.
module ppm_link_phy #(
  parameter int PULSE_CT = 7500,
  parameter int N_MOD    = 2,
  parameter int L        = 15000,
  parameter int N_PKT    = 48,
  parameter int PRE_CT   = 4,
  parameter int DELTA    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_PKT-1:0] tx_data,
  input  logic             tx_start,
  output logic             tx_avail,
  output logic             tx_pulse,
  input  logic             rx_pulse,
  output logic [N_PKT-1:0] rx_data,
  output logic             rx_avail,
  output logic             rx_error,
  input  logic             rx_read,
  input  logic             lfsr_en,
  output logic [31:0]      lfsr_data
);

  localparam int N_SYM    = N_PKT / N_MOD;
  localparam int N_VAL    = 2 ** N_MOD;
  localparam int T_MAX    = L + N_VAL * PULSE_CT + DELTA;
  localparam int CW       = $clog2(T_MAX + 2);
  localparam int LAST_IDX = PRE_CT + N_SYM;
  localparam int IW       = $clog2(LAST_IDX + 1);
  localparam int SW       = $clog2(N_SYM + 1);

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  tx_state_t        tx_state, tx_state_nxt;
  logic [CW-1:0]    tx_cnt, tx_cnt_nxt;
  logic [IW-1:0]    tx_idx, tx_idx_nxt;
  logic [N_PKT-1:0] tx_shreg, tx_shreg_nxt;
  logic [CW-1:0]    tx_interval;
  logic [N_MOD-1:0] tx_sym;

  assign tx_sym   = tx_shreg[N_PKT-1 -: N_MOD];
  assign tx_avail = (tx_state == TX_IDLE);

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_idx_nxt   = tx_idx;
    tx_shreg_nxt = tx_shreg;
    if (tx_idx < IW'(PRE_CT))
      tx_interval = CW'(L);
    else
      tx_interval = CW'(L) + CW'(PULSE_CT) * (CW'(tx_sym) + CW'(1));

    unique case (tx_state)
      TX_IDLE: begin
        if (tx_start) begin
          tx_state_nxt = TX_BUSY;
          tx_cnt_nxt   = '0;
          tx_idx_nxt   = '0;
          tx_shreg_nxt = tx_data;
        end
      end
      TX_BUSY: begin
        // The closing pulse has no interval; leave once its low cycle is reached.
        if (tx_idx == IW'(LAST_IDX)) begin
          if (tx_cnt == CW'(PULSE_CT))
            tx_state_nxt = TX_IDLE;
          else
            tx_cnt_nxt = tx_cnt + CW'(1);
        end else if (tx_cnt == tx_interval - CW'(1)) begin
          tx_cnt_nxt = '0;
          tx_idx_nxt = tx_idx + IW'(1);
          if (tx_idx >= IW'(PRE_CT))
            tx_shreg_nxt = tx_shreg << N_MOD;
        end else begin
          tx_cnt_nxt = tx_cnt + CW'(1);
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      tx_pulse <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_idx   <= tx_idx_nxt;
      tx_shreg <= tx_shreg_nxt;
      tx_pulse <= (tx_state_nxt == TX_BUSY) && (tx_cnt_nxt < CW'(PULSE_CT));
    end
  end

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_HUNT, RX_SYNC, RX_DATA} rx_state_t;

  rx_state_t        rx_state, rx_state_nxt;
  logic             rx_prev;
  logic [CW-1:0]    rx_cnt, rx_cnt_nxt;
  logic             pre_seen, pre_seen_nxt;
  logic [N_PKT-1:0] rx_shreg, rx_shreg_nxt;
  logic [SW-1:0]    sym_cnt, sym_cnt_nxt;
  logic             rx_edge, timeout, is_pre, is_data;
  logic [N_MOD-1:0] data_sym;
  logic [N_PKT-1:0] shifted;
  logic             pkt_done, err_set;

  assign rx_edge = rx_pulse & ~rx_prev;
  assign timeout = rx_cnt > CW'(T_MAX);
  assign is_pre  = (rx_cnt >= CW'(L - DELTA)) && (rx_cnt <= CW'(L + DELTA));
  assign shifted = {rx_shreg[N_PKT-N_MOD-1:0], data_sym};

  // Classes are disjoint because DELTA < PULSE_CT/2, so at most one matches.
  always_comb begin
    is_data  = 1'b0;
    data_sym = '0;
    for (int v = 0; v < N_VAL; v++) begin
      if ((rx_cnt >= CW'(L + (v + 1) * PULSE_CT - DELTA)) &&
          (rx_cnt <= CW'(L + (v + 1) * PULSE_CT + DELTA))) begin
        is_data  = 1'b1;
        data_sym = N_MOD'(v);
      end
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    pre_seen_nxt = pre_seen;
    rx_shreg_nxt = rx_shreg;
    sym_cnt_nxt  = sym_cnt;
    pkt_done     = 1'b0;
    err_set      = 1'b0;
    // Interval counter: 1 on the cycle after an edge, saturating past the timeout.
    if (rx_edge)
      rx_cnt_nxt = CW'(1);
    else if (!timeout)
      rx_cnt_nxt = rx_cnt + CW'(1);
    else
      rx_cnt_nxt = rx_cnt;

    unique case (rx_state)
      RX_HUNT: begin
        if (rx_edge) begin
          rx_state_nxt = RX_SYNC;
          pre_seen_nxt = 1'b0;
        end
      end
      RX_SYNC: begin
        if (rx_edge) begin
          if (is_pre) begin
            pre_seen_nxt = 1'b1;
          end else if (is_data && pre_seen) begin
            rx_shreg_nxt = shifted;
            sym_cnt_nxt  = SW'(1);
            rx_state_nxt = RX_DATA;
          end else begin
            pre_seen_nxt = 1'b0;
          end
        end else if (timeout) begin
          rx_state_nxt = RX_HUNT;
        end
      end
      RX_DATA: begin
        if (rx_edge) begin
          if (is_data) begin
            rx_shreg_nxt = shifted;
            if (sym_cnt == SW'(N_SYM - 1)) begin
              pkt_done     = 1'b1;
              rx_state_nxt = RX_HUNT;
            end else begin
              sym_cnt_nxt = sym_cnt + SW'(1);
            end
          end else begin
            err_set      = 1'b1;
            rx_state_nxt = RX_SYNC;
            pre_seen_nxt = is_pre;
          end
        end else if (timeout) begin
          err_set      = 1'b1;
          rx_state_nxt = RX_HUNT;
        end
      end
      default: rx_state_nxt = RX_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_HUNT;
      rx_prev  <= 1'b0;
      rx_cnt   <= '0;
      pre_seen <= 1'b0;
      rx_shreg <= '0;
      sym_cnt  <= '0;
      rx_data  <= '0;
      rx_avail <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_prev  <= rx_pulse;
      rx_cnt   <= rx_cnt_nxt;
      pre_seen <= pre_seen_nxt;
      rx_shreg <= rx_shreg_nxt;
      sym_cnt  <= sym_cnt_nxt;
      if (pkt_done)
        rx_data <= shifted;
      // A packet or error landing in the same cycle as rx_read takes priority.
      if (pkt_done)
        rx_avail <= 1'b1;
      else if (rx_read)
        rx_avail <= 1'b0;
      if (err_set)
        rx_error <= 1'b1;
      else if (rx_read)
        rx_error <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // LFSR (taps 31, 21, 1, 0)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)
      lfsr_data <= 32'h0000_0001;
    else if (lfsr_en)
      lfsr_data <= {lfsr_data[30:0],
                    lfsr_data[31] ^ lfsr_data[21] ^ lfsr_data[1] ^ lfsr_data[0]};
  end

endmodule

// File: tb/tb_ppm_link_phy.sv
// Scoreboard bench for ppm_link_phy with shortened line-code timing; a monitor
// pops expected packets whenever rx_data presents a new packet.
module tb_ppm_link_phy;

  localparam int PULSE = 8;
  localparam int LL    = 16;
  localparam int DLT   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] tx_data;
  logic        tx_start;
  logic        tx_avail;
  logic        tx_pulse;
  logic        rx_pulse;
  logic [47:0] rx_data;
  logic        rx_avail;
  logic        rx_error;
  logic        rx_read;
  logic        lfsr_en;
  logic [31:0] lfsr_data;

  logic        loop_en;
  logic        drv_pulse;
  assign rx_pulse = loop_en ? tx_pulse : drv_pulse;

  ppm_link_phy #(
    .PULSE_CT(PULSE), .N_MOD(2), .L(LL), .N_PKT(48), .PRE_CT(4), .DELTA(DLT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_avail (tx_avail),
    .tx_pulse (tx_pulse),
    .rx_pulse (rx_pulse),
    .rx_data  (rx_data),
    .rx_avail (rx_avail),
    .rx_error (rx_error),
    .rx_read  (rx_read),
    .lfsr_en  (lfsr_en),
    .lfsr_data(lfsr_data)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [47:0] exp_q[$];
  logic        mon_prev_avail = 1'b0;
  logic [47:0] mon_prev_data  = '0;
  logic [47:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: a rising rx_avail or a changed rx_data while valid is a new packet.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rx_avail && (!mon_prev_avail || rx_data != mon_prev_data)) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_packet", 64'(exp_q.size()), 64'(1));
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_data", 64'(rx_data), 64'(mon_exp));
          check("rx_error_on_pkt", 64'(rx_error), 64'(0));
        end
      end
      mon_prev_avail = rx_avail;
      mon_prev_data  = rx_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_tx_idle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (tx_avail) done = 1'b1;
    end
    check(name, 64'(done), 64'(1));
  endtask

  // Loopback send; optionally fires an extra tx_start mid-packet that must be ignored.
  task automatic send_loop(input logic [47:0] d, input bit extra_start);
    int   pulses;
    int   since_fall;
    logic prev;
    bit   done;
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    exp_q.push_back(d);
    @(negedge clk);
    tx_start = 1'b0;
    check("tx_avail_fall", 64'(tx_avail), 64'(0));
    check("tx_first_edge", 64'(tx_pulse), 64'(1));
    pulses = 1; since_fall = -1; prev = tx_pulse; done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (extra_start && c == 40) begin
        tx_data  = 48'hffff_0000_ffff;
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk);
      if (tx_pulse && !prev) pulses++;
      if (!tx_pulse && prev) since_fall = 0;
      else if (since_fall >= 0) since_fall++;
      if (tx_avail) begin
        done = 1'b1;
        check("tx_avail_after_fall", 64'(since_fall), 64'(1));
      end
      prev = tx_pulse;
    end
    tx_start = 1'b0;
    check("tx_done", 64'(done), 64'(1));
    check("pulse_count", 64'(pulses), 64'(29));
    repeat (5) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'(0));
    check("rx_avail_set", 64'(rx_avail), 64'(1));
  endtask

  task automatic drv_interval(input int iv);
    drv_pulse = 1'b1;
    repeat (PULSE) @(negedge clk);
    drv_pulse = 1'b0;
    repeat (iv - PULSE) @(negedge clk);
  endtask

  task automatic drv_close();
    drv_pulse = 1'b1;
    repeat (PULSE) @(negedge clk);
    drv_pulse = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drv_preamble();
    repeat (4) drv_interval(LL);
  endtask

  logic [47:0] word;
  int          edges;
  logic        prev_p;

  initial begin
    rst = 1'b1; tx_data = '0; tx_start = 1'b0; rx_read = 1'b0;
    lfsr_en = 1'b0; loop_en = 1'b0; drv_pulse = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_avail",  64'(tx_avail),  64'(1));
    check("reset_tx_pulse",  64'(tx_pulse),  64'(0));
    check("reset_rx_avail",  64'(rx_avail),  64'(0));
    check("reset_rx_error",  64'(rx_error),  64'(0));
    check("reset_rx_data",   64'(rx_data),   64'(0));
    check("reset_lfsr",      64'(lfsr_data), 64'(32'h1));
    rst = 1'b0;

    // LFSR stepping and hold
    lfsr_en = 1'b1;
    @(negedge clk); check("lfsr_1", 64'(lfsr_data), 64'(32'h3));
    @(negedge clk); check("lfsr_2", 64'(lfsr_data), 64'(32'h6));
    @(negedge clk); check("lfsr_3", 64'(lfsr_data), 64'(32'hd));
    lfsr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("lfsr_hold", 64'(lfsr_data), 64'(32'hd));

    // Loopback packets
    loop_en = 1'b1;
    send_loop(48'h3c12_3fee_dbac, 1'b0);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    check("rx_read_clears", 64'(rx_avail), 64'(0));
    send_loop(48'h3c0f_eedb_ac5a, 1'b1);

    // Decoder joins mid-preamble; rx_avail is still set so rx_data is overwritten
    loop_en = 1'b0;
    @(negedge clk);
    tx_data  = 48'h0123_4567_89ab;
    tx_start = 1'b1;
    exp_q.push_back(48'h0123_4567_89ab);
    @(negedge clk);
    tx_start = 1'b0;
    edges = 1; prev_p = tx_pulse;
    for (int c = 0; c < 200 && !(edges == 2 && !tx_pulse); c++) begin
      @(negedge clk);
      if (tx_pulse && !prev_p) edges++;
      prev_p = tx_pulse;
    end
    check("mid_pre_two_edges", 64'(edges), 64'(2));
    loop_en = 1'b1;
    wait_tx_idle("mid_pre_tx_done");
    repeat (5) @(negedge clk);
    check("mid_pre_sb_empty", 64'(exp_q.size()), 64'(0));
    check("overwrite_avail", 64'(rx_avail), 64'(1));
    loop_en = 1'b0;

    // Reset in the middle of a transmission
    @(negedge clk);
    tx_data  = 48'haaaa_5555_aaaa;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx_avail", 64'(tx_avail),  64'(1));
    check("midrst_tx_pulse", 64'(tx_pulse),  64'(0));
    check("midrst_rx_avail", 64'(rx_avail),  64'(0));
    check("midrst_lfsr",     64'(lfsr_data), 64'(32'h1));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_quiet", 64'(tx_pulse), 64'(0));

    // Off-grid interval while still syncing: silently dropped
    reset_dut();
    drv_preamble();
    drv_interval(LL + PULSE / 2);
    drv_close();
    check("sync_bad_no_err", 64'(rx_error), 64'(0));
    check("sync_bad_no_pkt", 64'(rx_avail), 64'(0));

    // Off-grid interval after a data symbol: error
    reset_dut();
    drv_preamble();
    drv_interval(LL + PULSE);
    drv_interval(LL + PULSE / 2);
    drv_close();
    check("data_bad_err",    64'(rx_error), 64'(1));
    check("data_bad_no_pkt", 64'(rx_avail), 64'(0));
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    check("rx_read_clears_err", 64'(rx_error), 64'(0));

    // One past tolerance after a data symbol: error
    reset_dut();
    drv_preamble();
    drv_interval(LL + PULSE);
    drv_interval(LL + PULSE + DLT + 1);
    drv_close();
    check("tol_plus1_err", 64'(rx_error), 64'(1));

    // Full packet driven at the +/-DELTA edges of the tolerance window
    reset_dut();
    word = 48'h1b1b_1b1b_1b1b;
    exp_q.push_back(word);
    drv_preamble();
    for (int i = 0; i < 24; i++)
      drv_interval(LL + (int'(word[47 - 2 * i -: 2]) + 1) * PULSE + ((i % 2 == 0) ? DLT : -DLT));
    drv_close();
    check("tol_edge_sb_empty", 64'(exp_q.size()), 64'(0));
    check("tol_edge_no_err",   64'(rx_error),     64'(0));
    check("tol_edge_avail",    64'(rx_avail),     64'(1));

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
